fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage that sits directly upstream of the combinational instruction memory. It owns the program counter and drives the memory's byte address. It captures the returned instruction word into a registered output toward decode, using a valid/ready handshake. It supports stall from decode, PC redirect (branch/flush), a run enable, and an out-of-range fault when the PC leaves the populated instruction memory.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; low 2 bits are ignored (forced to 0).
- IMEM_WORDS, 64: number of populated 32-bit words in instruction memory; the legal byte range is 0 .. IMEM_WORDS*4-1.

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- en  in  1  run enable; when low, no new fetches are issued.
- imem_a  out  32  byte address to instruction memory; combinationally equal to the PC register.
- imem_rd  in  32  instruction word returned combinationally by memory for imem_a.
- redirect_valid  in  1  load a new PC and flush the output register.
- redirect_pc  in  32  redirect target; bits [1:0] are forced to 0.
- id_valid  out  1  id_instr/id_pc hold a valid instruction.
- id_ready  in  1  decode accepts the instruction this cycle.
- id_instr  out  32  fetched instruction word.
- id_pc  out  32  byte address id_instr was fetched from.
- id_pc_plus4  out  32  id_pc + 4 (modulo 2^32), registered.
- fault  out  1  PC out of range; fetching is halted.

## Operation
- **States:** BOOT, RUN, FAULT.
- **Reset values:**
  - state = BOOT
  - pc = RESET_PC & ~3
  - id_valid = 0
  - id_instr = 0
  - id_pc = 0
  - id_pc_plus4 = 0
  - fault = 0
- **BOOT:** transitions to RUN on the next edge regardless of en. No fetch occurs in BOOT.
- **Fire condition (RUN):** fire = en && (!id_valid || id_ready) && !redirect_valid && in_range.
  - in_range = (pc[31:2] < IMEM_WORDS).
- **On fire:**
  - id_instr <= imem_rd
  - id_pc <= pc
  - id_pc_plus4 <= pc + 4
  - id_valid <= 1
  - pc <= pc + 4
- **Stall:** if id_valid && !id_ready, pc and all id_* outputs hold.
- **Drain:** if there is no fire and id_valid && id_ready, then id_valid <= 0. id_instr, id_pc and id_pc_plus4 retain their old values.
- **Out of range:** in RUN, if the fire conditions hold except in_range = 0, then state <= FAULT and fault <= 1.
  - The PC holds.
  - A pending id_valid still drains normally through the handshake.
- **FAULT:** no fetches; fault stays 1. The state is left only by redirect or reset.
- **Redirect (highest priority, any state, independent of en):**
  - pc <= redirect_pc & ~3
  - id_valid <= 0
  - fault <= 0
  - state <= RUN
  - No fetch occurs in the redirect cycle, even if id_ready is high. An instruction handed over in that same cycle counts as accepted by decode.
- **Arithmetic:** pc + 4 wraps modulo 2^32. The out-of-range check catches the PC before any wrap is observable.
- **en = 0:** the PC holds and draining still occurs. Deasserting en does not clear fault.

## Timing
- imem_a changes only at clock edges (or on async reset), because it is a direct copy of the pc register.
- **Latency from reset release:**
  - edge 1: BOOT → RUN.
  - edge 2: first fetch; id_valid = 1 with id_pc = RESET_PC.
- **Throughput:** one instruction per cycle while en = 1 and id_ready = 1.
- **Redirect latency:**
  - redirect asserted in cycle N.
  - edge N: pc = target, id_valid = 0.
  - edge N+1: id_valid = 1 with id_pc = target.
  - Exactly one bubble.
- **Fault latency:** fault rises on the edge following the first cycle in which RUN sees an out-of-range PC with fire otherwise allowed.
- **Reset mid-operation:** all outputs take their reset values asynchronously, without waiting for a clock edge. Fetching resumes via BOOT after release.

## Test plan
- **Boot and stream:** RESET_PC = 0, en = 1, id_ready = 1, imem_rd = 32'hA000_0000 | imem_a.
  - Release reset → id_valid first rises after edge 2 with id_pc = 0, id_instr = A000_0000, id_pc_plus4 = 4.
  - Then id_pc = 4, 8, 0xC on consecutive cycles.
- **Stall:** id_ready low for 3 cycles while id_pc = 8 → id_instr, id_pc and imem_a (= 0xC) hold for all 3 cycles. After id_ready rises, the next accepted id_pc is 0xC with no skip or duplicate.
- **Redirect:** redirect_valid for one cycle, redirect_pc = 32'h23.
  - Next cycle: id_valid = 0, imem_a = 0x20.
  - One cycle later: id_pc = 0x20, id_pc_plus4 = 0x24.
- **Out of range:** IMEM_WORDS = 64, stream from 0xF8.
  - id_pc = 0xF8, then 0xFC.
  - Then fault = 1, imem_a = 0x100, id_valid = 0 after the drain.
  - Redirect to 0x10 → fault = 0, and id_pc = 0x10 one bubble later.
- **Redirect priority:** redirect with en = 0 and a stall pending (id_valid = 1, id_ready = 0) → pc takes the target and id_valid = 0 on the next edge. With en held low, no further fetches occur.
- **Async reset mid-stall:** assert reset between clock edges while id_valid = 1 → id_valid, id_instr, id_pc and fault go to 0, and imem_a goes to RESET_PC, before the next edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address,
// and registers the fetched word toward decode over a valid/ready handshake.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        fault
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [31:0] PC_INIT  = RESET_PC & ~32'h3;
  localparam logic [29:0] WORD_LIM = 30'(IMEM_WORDS);

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        in_range;
  logic        can_issue;
  logic        fire;
  logic        oor;

  assign pc_plus4  = pc + 32'd4;
  assign in_range  = (pc[31:2] < WORD_LIM);
  assign can_issue = en && (!id_valid || id_ready)
                     && !redirect_valid;
  assign imem_a    = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (redirect_valid) begin
      state_nx = RUN;
    end else begin
      case (state)
        BOOT:    state_nx = RUN;
        RUN:     state_nx = oor ? FAULT : RUN;
        FAULT:   state_nx = FAULT;
        default: state_nx = BOOT;
      endcase
    end
  end

  always_comb begin
    fire  = 1'b0;
    oor   = 1'b0;
    fault = 1'b0;
    case (state)
      RUN: begin
        fire = can_issue && in_range;
        oor  = can_issue && !in_range;
      end
      FAULT:   fault = 1'b1;
      default: ;
    endcase
  end

  // Redirect wins over everything, including a pending stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= PC_INIT;
    end else if (redirect_valid) begin
      pc <= redirect_pc & ~32'h3;
    end else if (fire) begin
      pc <= pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_valid <= 1'b0;
    end else if (redirect_valid) begin
      id_valid <= 1'b0;
    end else if (fire) begin
      id_valid <= 1'b1;
    end else if (id_ready) begin
      id_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_instr    <= '0;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
    end else if (fire) begin
      id_instr    <= imem_rd;
      id_pc       <= pc;
      id_pc_plus4 <= pc_plus4;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, stream, stall, redirect,
// out-of-range fault and asynchronous reset.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        en;
  logic [31:0] imem_a;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        fault;

  int n_chk;
  int n_err;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(64)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .imem_a        (imem_a),
    .imem_rd       (imem_rd),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_pc_plus4   (id_pc_plus4),
    .fault         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb imem_rd = 32'hA000_0000 | imem_a;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk          = 0;
    n_err          = 0;
    reset          = 1'b1;
    en             = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    step();
    step();
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_pc4", id_pc_plus4, 32'h0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_imem_a", imem_a, 32'h0);

    reset = 1'b0;
    step();
    chk("boot_valid", 32'(id_valid), 32'd0);
    step();
    chk("first_valid", 32'(id_valid), 32'd1);
    chk("first_pc", id_pc, 32'h0);
    chk("first_instr", id_instr, 32'hA000_0000);
    chk("first_pc4", id_pc_plus4, 32'h4);
    step();
    chk("stream_pc4", id_pc, 32'h4);
    step();
    chk("stream_pc8", id_pc, 32'h8);

    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", 32'(id_valid), 32'd1);
      chk("stall_pc", id_pc, 32'h8);
      chk("stall_instr", id_instr, 32'hA000_0008);
      chk("stall_imem_a", imem_a, 32'hC);
    end
    id_ready = 1'b1;
    step();
    chk("resume_pc", id_pc, 32'hC);
    step();
    chk("resume_pc2", id_pc, 32'h10);

    redirect_valid = 1'b1;
    redirect_pc    = 32'h23;
    step();
    redirect_valid = 1'b0;
    chk("redir_valid", 32'(id_valid), 32'd0);
    chk("redir_imem_a", imem_a, 32'h20);
    step();
    chk("redir_tgt_valid", 32'(id_valid), 32'd1);
    chk("redir_tgt_pc", id_pc, 32'h20);
    chk("redir_tgt_pc4", id_pc_plus4, 32'h24);
    chk("redir_tgt_instr", id_instr, 32'hA000_0020);

    redirect_valid = 1'b1;
    redirect_pc    = 32'hF8;
    step();
    redirect_valid = 1'b0;
    chk("oor_bubble", 32'(id_valid), 32'd0);
    step();
    chk("oor_pc_f8", id_pc, 32'hF8);
    step();
    chk("oor_pc_fc", id_pc, 32'hFC);
    chk("oor_imem_a_pre", imem_a, 32'h100);
    chk("oor_fault_pre", 32'(fault), 32'd0);
    step();
    chk("oor_fault", 32'(fault), 32'd1);
    chk("oor_imem_a", imem_a, 32'h100);
    chk("oor_drain", 32'(id_valid), 32'd0);
    chk("oor_hold_pc", id_pc, 32'hFC);
    en = 1'b0;
    step();
    chk("oor_en0_fault", 32'(fault), 32'd1);
    en = 1'b1;
    step();
    chk("oor_stay_fault", 32'(fault), 32'd1);
    chk("oor_stay_valid", 32'(id_valid), 32'd0);

    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    step();
    redirect_valid = 1'b0;
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_valid", 32'(id_valid), 32'd0);
    chk("clr_imem_a", imem_a, 32'h10);
    step();
    chk("clr_pc", id_pc, 32'h10);
    chk("clr_valid2", 32'(id_valid), 32'd1);

    id_ready = 1'b0;
    en       = 1'b0;
    step();
    chk("prio_stall_pc", id_pc, 32'h10);
    chk("prio_stall_a", imem_a, 32'h14);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    chk("prio_imem_a", imem_a, 32'h40);
    chk("prio_valid", 32'(id_valid), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("prio_en0_valid", 32'(id_valid), 32'd0);
      chk("prio_en0_a", imem_a, 32'h40);
    end

    en = 1'b1;
    step();
    chk("ars_fetch_pc", id_pc, 32'h40);
    chk("ars_fetch_valid", 32'(id_valid), 32'd1);
    step();
    chk("ars_stall_valid", 32'(id_valid), 32'd1);
    chk("ars_stall_pc", id_pc, 32'h40);
    #2;
    reset = 1'b1;
    #1;
    chk("ars_valid", 32'(id_valid), 32'd0);
    chk("ars_instr", id_instr, 32'h0);
    chk("ars_pc", id_pc, 32'h0);
    chk("ars_pc4", id_pc_plus4, 32'h0);
    chk("ars_fault", 32'(fault), 32'd0);
    chk("ars_imem_a", imem_a, 32'h0);
    id_ready = 1'b1;
    reset    = 1'b0;
    step();
    chk("reboot_valid", 32'(id_valid), 32'd0);
    step();
    chk("reboot_pc", id_pc, 32'h0);
    chk("reboot_valid2", 32'(id_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
